// File: rtl/window_gen_3x3.sv
// -----------------------------------------------------------------------------
// window_gen_3x3
//
// Streaming 3x3 neighbourhood generator feeding the median-filter datapath.
// A raster-order pixel stream (one pixel per accepted cycle) is buffered in
// two line memories. Every interior 3x3 window D0..D8 is emitted together with
// its top-left (row, col) coordinate, one cycle after the pixel that completes
// it was accepted.
//
// Parameters
//   WIDTH       image width in pixels  (3..1023)
//   HEIGHT      image height in lines  (3..1023)
//
// Ports
//   clk         in   1   rising-edge clock
//   rst_n       in   1   asynchronous active-low reset
//   pix_in      in   8   input pixel, raster order, (0,0) first
//   pix_valid   in   1   pix_in accepted this cycle (gaps allowed, no stall)
//   win_valid   out  1   window outputs valid this cycle
//   win_row     out  10  window top-left row, 0..HEIGHT-3
//   win_col     out  10  window top-left col, 0..WIDTH-3
//   D0..D8      out  8   D0..D2 row r, D3..D5 row r+1, D6..D8 row r+2
//                        (each row ordered col c, c+1, c+2)
//   frame_done  out  1   pulse coincident with the last window of a frame
// -----------------------------------------------------------------------------
module window_gen_3x3 #(
    parameter int WIDTH  = 430,
    parameter int HEIGHT = 554
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] pix_in,
    input  logic       pix_valid,
    output logic       win_valid,
    output logic [9:0] win_row,
    output logic [9:0] win_col,
    output logic [7:0] D0,
    output logic [7:0] D1,
    output logic [7:0] D2,
    output logic [7:0] D3,
    output logic [7:0] D4,
    output logic [7:0] D5,
    output logic [7:0] D6,
    output logic [7:0] D7,
    output logic [7:0] D8,
    output logic       frame_done
);

    // Line-memory address width; the column counter never exceeds WIDTH-1,
    // so its low bits always form an in-range index.
    localparam int         AW       = $clog2(WIDTH);
    localparam logic [9:0] COL_LAST = 10'(WIDTH - 1);
    localparam logic [9:0] ROW_LAST = 10'(HEIGHT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [9:0]  r_in_row;
    logic [9:0]  r_in_col;

    // lineA holds row in_row-2, lineB holds row in_row-1
    logic [7:0]  r_line_a [0:WIDTH-1];
    logic [7:0]  r_line_b [0:WIDTH-1];

    logic [7:0]  r_win [0:8];
    logic        r_win_valid;
    logic        r_frame_done;
    logic [9:0]  r_win_row;
    logic [9:0]  r_win_col;

    logic [AW-1:0] w_idx;
    logic [7:0]    w_tap_a;
    logic [7:0]    w_tap_b;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_frame_last;
    logic          w_emit;

    assign w_idx        = r_in_col[AW-1:0];
    assign w_tap_a      = r_line_a[w_idx];
    assign w_tap_b      = r_line_b[w_idx];
    assign w_col_last   = (r_in_col == COL_LAST);
    assign w_row_last   = (r_in_row == ROW_LAST);
    assign w_frame_last = w_col_last && w_row_last;

    // Raster position counters: advance on every accepted pixel, wrap per line and frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_row <= 10'd0;
            r_in_col <= 10'd0;
        end else if (pix_valid) begin
            if (w_col_last) begin
                r_in_col <= 10'd0;
                r_in_row <= w_row_last ? 10'd0 : (r_in_row + 10'd1);
            end else begin
                r_in_col <= r_in_col + 10'd1;
                r_in_row <= r_in_row;
            end
        end else begin
            r_in_row <= r_in_row;
            r_in_col <= r_in_col;
        end
    end

    // Line memories: not reset, the first two rows of every frame overwrite them
    always_ff @(posedge clk) begin
        if (pix_valid) begin
            r_line_a[w_idx] <= w_tap_b;
            r_line_b[w_idx] <= pix_in;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and window-emit decision; the state only moves on accepts.
    // In S_RUN the row counter is >= 2, so only the column test remains; it also
    // flushes the two stale columns left over from the previous line.
    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (pix_valid) begin
                    w_state_nxt = S_FILL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_FILL: begin
                if (pix_valid && w_col_last && (r_in_row == 10'd1)) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_FILL;
                end
            end
            S_RUN: begin
                w_emit = pix_valid && (r_in_col >= 10'd2);
                if (pix_valid && w_frame_last) begin
                    w_state_nxt = S_FILL;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_emit      = 1'b0;
            end
        endcase
    end

    // 3x3 window shift register: newest column enters at D2/D5/D8
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= 8'd0;
            end
        end else if (pix_valid) begin
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= w_tap_a;
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= w_tap_b;
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= pix_in;
        end else begin
            for (int k = 0; k < 9; k++) begin
                r_win[k] <= r_win[k];
            end
        end
    end

    // Output strobes and window coordinates; coordinates hold between windows
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_win_row    <= 10'd0;
            r_win_col    <= 10'd0;
        end else begin
            r_win_valid  <= w_emit;
            r_frame_done <= w_emit && w_frame_last;
            if (w_emit) begin
                r_win_row <= r_in_row - 10'd2;
                r_win_col <= r_in_col - 10'd2;
            end else begin
                r_win_row <= r_win_row;
                r_win_col <= r_win_col;
            end
        end
    end

    assign win_valid  = r_win_valid;
    assign frame_done = r_frame_done;
    assign win_row    = r_win_row;
    assign win_col    = r_win_col;
    assign D0         = r_win[0];
    assign D1         = r_win[1];
    assign D2         = r_win[2];
    assign D3         = r_win[3];
    assign D4         = r_win[4];
    assign D5         = r_win[5];
    assign D6         = r_win[6];
    assign D7         = r_win[7];
    assign D8         = r_win[8];

endmodule

// File: tb/tb_window_gen_3x3.sv
// -----------------------------------------------------------------------------
// tb_window_gen_3x3
//
// Self-checking bench for window_gen_3x3 on a 5x4 image. A reference model keeps
// the received image in a 2-D array and forms each expected window directly
// from image coordinates; a single compare process checks the DUT every cycle
// and also pins a few hand-computed windows and per-scenario window counts.
// -----------------------------------------------------------------------------
module tb_window_gen_3x3;

    localparam int MW = 5;
    localparam int MH = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] pix_in;
    logic       pix_valid;
    logic       win_valid;
    logic [9:0] win_row;
    logic [9:0] win_col;
    logic [7:0] D0, D1, D2, D3, D4, D5, D6, D7, D8;
    logic       frame_done;

    window_gen_3x3 #(.WIDTH(MW), .HEIGHT(MH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .D0         (D0),
        .D1         (D1),
        .D2         (D2),
        .D3         (D3),
        .D4         (D4),
        .D5         (D5),
        .D6         (D6),
        .D7         (D7),
        .D8         (D8),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] img [0:MH-1][0:MW-1];
    int         mr, mc;
    logic       exp_valid, exp_fd;
    int         exp_row, exp_col;
    logic [7:0] exp_d [0:8];

    // pixel (r,c) of the current frame, including the one arriving right now
    function automatic logic [7:0] px(input int r, input int c);
        if (r == mr && c == mc) return pix_in;
        return img[r][c];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            mr        <= 0;
            mc        <= 0;
            exp_valid <= 1'b0;
            exp_fd    <= 1'b0;
        end else if (pix_valid) begin
            img[mr][mc] <= pix_in;
            exp_valid   <= (mr >= 2) && (mc >= 2);
            exp_fd      <= (mr == MH - 1) && (mc == MW - 1);
            if (mr >= 2 && mc >= 2) begin
                exp_row <= mr - 2;
                exp_col <= mc - 2;
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_d[i*3+j] <= px(mr - 2 + i, mc - 2 + j);
            end
            if (mc == MW - 1) begin
                mc <= 0;
                mr <= (mr == MH - 1) ? 0 : mr + 1;
            end else begin
                mc <= mc + 1;
            end
        end else begin
            exp_valid <= 1'b0;
            exp_fd    <= 1'b0;
        end
    end

    // ---------------- compare process ----------------
    int n_cmp = 0;
    int n_err = 0;
    int win_cnt = 0, fd_cnt = 0, base_win = 0, base_fd = 0;
    int chk_req = 0, seen_req = 0, req_win = 0, req_fd = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        logic [7:0] d [0:8];
        forever begin
            @(negedge clk);
            d = '{D0, D1, D2, D3, D4, D5, D6, D7, D8};
            if (!rst_n) begin
                chk("rst_win_valid", int'(win_valid), 0);
                chk("rst_frame_done", int'(frame_done), 0);
                chk("rst_win_row", int'(win_row), 0);
                chk("rst_win_col", int'(win_col), 0);
                chk("rst_D4", int'(D4), 0);
            end else begin
                chk("win_valid", int'(win_valid), int'(exp_valid));
                chk("frame_done", int'(frame_done), int'(exp_fd));
                if (exp_valid && win_valid) begin
                    chk("win_row", int'(win_row), exp_row);
                    chk("win_col", int'(win_col), exp_col);
                    for (int k = 0; k < 9; k++) chk($sformatf("D%0d", k), int'(d[k]), int'(exp_d[k]));
                    // hand-computed anchors (5x4, pixel = row*16+col)
                    case (win_cnt)
                        0, 6, 24: begin
                            chk("first_D0", int'(D0), 'h00); chk("first_D1", int'(D1), 'h01);
                            chk("first_D2", int'(D2), 'h02); chk("first_D4", int'(D4), 'h11);
                            chk("first_D8", int'(D8), 'h22); chk("first_row", int'(win_row), 0);
                            chk("first_col", int'(win_col), 0);
                        end
                        5, 11, 29: begin
                            chk("last_D0", int'(D0), 'h12); chk("last_D8", int'(D8), 'h34);
                            chk("last_fd", int'(frame_done), 1); chk("last_row", int'(win_row), 1);
                            chk("last_col", int'(win_col), 2);
                        end
                        18: begin
                            chk("f2_D0", int'(D0), 'h80); chk("f2_D4", int'(D4), 'h91);
                        end
                        default: ;
                    endcase
                end
                if (win_valid) win_cnt++;
                if (frame_done) fd_cnt++;
            end
            if (chk_req != seen_req) begin
                chk("window_count", win_cnt - base_win, req_win);
                chk("frame_done_count", fd_cnt - base_fd, req_fd);
                base_win = win_cnt;
                base_fd  = fd_cnt;
                seen_req = chk_req;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic v, input logic [7:0] d);
        pix_valid = v;
        pix_in    = d;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom_range(0, 255)));
    endtask

    task automatic send_frame(input logic [7:0] base, input bit gaps);
        for (int r = 0; r < MH; r++)
            for (int c = 0; c < MW; c++) begin
                if (gaps) idle($urandom_range(0, 2));
                step(1'b1, base + 8'(r * 16 + c));
            end
    endtask

    task automatic expect_counts(input int w, input int f);
        idle(2);
        req_win = w;
        req_fd  = f;
        chk_req = chk_req + 1;
        idle(2);
    endtask

    initial begin
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_in    = 8'd0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        idle(2);

        // 1: continuous frame
        send_frame(8'h00, 1'b0);
        expect_counts(6, 1);

        // 2: same frame with random gaps
        send_frame(8'h00, 1'b1);
        expect_counts(6, 1);

        // 3: back-to-back frames, second one offset by 0x80
        send_frame(8'h00, 1'b0);
        send_frame(8'h80, 1'b0);
        expect_counts(12, 2);

        // 4: reset after 8 pixels, then a full frame from (0,0)
        for (int i = 0; i < 8; i++) step(1'b1, 8'((i / MW) * 16 + (i % MW)));
        pix_valid = 1'b0;
        rst_n     = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        send_frame(8'h00, 1'b0);
        expect_counts(6, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
